// File: rtl/demux1to4_reg.sv
// demux1to4_reg: registered 1-to-4 demultiplexer with valid/ready handshakes
//   Each output channel has one holding register. A word is accepted when
//   In_valid & In_ready, and it appears on its channel one cycle later.
//   Optional per-channel drain counters are built with macro DEMUX_CNT_EN.
// Ports:
//   Clock    - rising-edge clock
//   Resetn   - asynchronous active-low reset
//   En       - enable; 0 blocks acceptance of new input
//   D, S     - input word and destination channel select
//   In_valid - D and S are valid this cycle
//   In_ready - block can accept the word this cycle
//   Y        - channel data, channel k at [k*N +: N]
//   Y_valid  - per-channel valid
//   Y_ready  - per-channel consumer ready
//   Cnt      - per-channel saturating drain counters, channel k at [8k +: 8]
module demux1to4_reg #(
  parameter int N = 8
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           En,
  input  logic [N-1:0]   D,
  input  logic [1:0]     S,
  input  logic           In_valid,
  output logic           In_ready,
  output logic [4*N-1:0] Y,
  output logic [3:0]     Y_valid,
  input  logic [3:0]     Y_ready,
  output logic [31:0]    Cnt
);
  logic [3:0]   v_q, v_d, ld, dr;
  logic [N-1:0] y_q [4];
  logic         acc;
  // Resetn gating keeps In_ready low for the whole reset window.
  assign In_ready = Resetn & En & (~v_q[S] | Y_ready[S]);
  // With In_valid low, acc is 0 even if S/D are X, so nothing unknown loads.
  assign acc = In_valid & In_ready;
  assign ld  = acc ? (4'b0001 << S) : 4'b0000;
  assign dr  = v_q & Y_ready;
  assign v_d = ld | (v_q & ~dr);
  assign Y_valid = v_q;
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      v_q <= '0;
      for (int k = 0; k < 4; k++) y_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < 4; k++) if (ld[k]) y_q[k] <= D;
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_y
    assign Y[g*N +: N] = y_q[g];
  end
`ifdef DEMUX_CNT_EN
  logic [7:0] cnt_q [4];
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) if (dr[k] && cnt_q[k] != 8'hFF) cnt_q[k] <= cnt_q[k] + 8'd1;
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign Cnt[g*8 +: 8] = cnt_q[g];
  end
`else
  assign Cnt = '0;
`endif
endmodule

// File: doc/demux1to4_reg.md
DEMUX1TO4_REG -- requirements
Module: demux1to4_reg

Interface
REQ-001 SHALL have parameter N, default 8, the data width of each channel in bits.
REQ-002 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port En  input  1  enable; 0 blocks acceptance of new input.
REQ-005 SHALL have port D  input  N  input data word.
REQ-006 SHALL have port S  input  2  destination channel select, 0..3.
REQ-007 SHALL have port In_valid  input  1  D and S are valid this cycle.
REQ-008 SHALL have port In_ready  output  1  block can accept the word this cycle.
REQ-009 SHALL have port Y  output  4*N  channel data; channel k occupies bits [k*N+N-1 : k*N].
REQ-010 SHALL have port Y_valid  output  4  per-channel valid; bit k belongs to channel k.
REQ-011 SHALL have port Y_ready  input  4  per-channel consumer ready; bit k belongs to channel k.
REQ-012 SHALL have port Cnt  output  32  per-channel transfer counters, 8 bits each; channel k occupies bits [8k+7 : 8k].

Function
REQ-013 SHALL give each channel k one holding register (data plus valid flag V[k]); Y_valid[k] = V[k] and Y[k] = the held data.
REQ-014 SHALL drive In_ready = En & (~V[S] | Y_ready[S]); In_ready is combinational in S, En, V and Y_ready.
REQ-015 SHALL accept a word when In_valid & In_ready: on that edge the channel S register loads D and V[S] is set.
REQ-016 SHALL present an accepted word on Y_valid[S] exactly one cycle after acceptance (latency 1), with no combinational path from D to Y.
REQ-017 SHALL complete a drain on channel k when V[k] & Y_ready[k]; V[k] clears unless a load to channel k occurs on the same edge.
REQ-018 SHALL let a load and a drain on the same channel in the same cycle both occur, leaving V[k]=1 with the new data.
REQ-019 SHALL let drains on any or all channels occur in the same cycle as a load to a different channel, each independently.
REQ-020 SHALL hold a channel's data and valid stable while V[k]=1 and Y_ready[k]=0; a full channel blocks only input addressed to it.
REQ-021 SHALL leave all state unchanged when In_valid=0 or En=0, apart from drains.
REQ-022 SHALL ignore D and S when In_valid=0; X on those inputs SHALL NOT propagate to state.
REQ-023 SHALL never load more than one channel per cycle: exactly the decoded channel S, one-hot.

Reset
REQ-024 SHALL, while Resetn=0, immediately force V=4'b0000, all Y bits to 0 and all Cnt bits to 0, independent of Clock.
REQ-025 SHALL discard any held words when reset is asserted mid-operation; no acceptance or drain occurs on an edge while Resetn=0.
REQ-026 SHALL hold In_ready=0 during reset; after reset deasserts, In_ready follows REQ-014 from the first cycle.

Configuration
REQ-027 SHALL, with macro DEMUX_CNT_EN defined, implement four 8-bit counters; counter k increments by 1 on each drain of channel k and saturates at 255.
REQ-028 SHALL, with DEMUX_CNT_EN undefined, implement no counter logic and tie Cnt to constant 0; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset with all Y_ready=1; S=2, D=8'hA5, In_valid=1 for one cycle -> next cycle Y_valid=4'b0100, channel 2 Y=8'hA5; the cycle after, Y_valid=0.
REQ-030 SHALL cover: all Y_ready=0; write channel 1 (8'h11), then S=1 again -> In_ready=0; S=3, 8'h33 -> accepted; Y_valid=4'b1010.
REQ-031 SHALL cover: channel 0 full, Y_ready[0]=1 while S=0, D=8'h5A, In_valid=1 -> In_ready=1; next cycle V[0]=1 with Y=8'h5A; no word lost or duplicated.
REQ-032 SHALL cover: En=0, In_valid=1, S=0 -> In_ready=0 and Y_valid stays 0; then set En=1 -> the word is accepted.
REQ-033 SHALL cover: channels 0 and 3 full, Resetn pulsed low between clock edges -> Y_valid=0 and Y=0 immediately, before the next edge.
REQ-034 SHALL cover, with DEMUX_CNT_EN defined: 300 drains on channel 2 -> Cnt[23:16]=8'd255 and the other counters are 0; with the macro undefined -> Cnt=0.
